uart_tx: RTL and testbench

UART transmitter that serialises bytes onto a single `tx` line in 8N1 format (1 start bit, 8 data bits LSB-first, 1 stop bit). Its bit timing is identical to `uart_rx`, so the two blocks loop back directly when both use the same `SAMPLE_COUNT`. A one-entry holding register lets the producer queue the next byte during a frame, giving back-to-back frames with no idle gap. It sits between the byte-producing logic and the board TX pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx.sv | 105 ++++++++++
 tb/tb_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and state type shared by the UART transmitter and receiver.
// Both blocks take their line levels and frame size from here, so their framing always matches.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter. It raises tick for one cycle on the last clock of every bit period.
// A synchronous clear restarts the period, which lets each FSM state begin on a fresh bit boundary.
module uart_baud_tick #(
  parameter int SAMPLE_COUNT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_COUNT);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_COUNT - 1);

  logic [CW-1:0] count;

  // The counter wraps on its own at the end of each period, so consecutive bits never drift.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register, so frames can run back to back.
// The FSM owns the shift register and the hold register. The bit timing comes from uart_baud_tick.
module uart_tx #(
  parameter int SAMPLE_COUNT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  import uart_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 accept;
  logic                 stop_end;
  logic                 clear;

  assign ready    = !hold_full;
  assign accept   = valid && ready;
  assign stop_end = (state == STOP) && tick;
  assign clear    = (state_next != state);

  uart_baud_tick #(
    .SAMPLE_COUNT(SAMPLE_COUNT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // At the end of the stop bit, a pending byte (held, or arriving on this same edge) starts a new frame at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: if (tick) state_next = DATA;
      DATA:  if (tick && bit_idx == LAST_BIT) state_next = STOP;
      STOP:  if (tick) state_next = (hold_full || accept) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx   = IDLE_LEVEL;
    busy = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   tx = START_LEVEL;
      DATA:    tx = shift_reg[0];
      STOP:    tx = STOP_LEVEL;
      default: busy = 1'b0;
    endcase
  end

  // An accept on the stop-end edge with hold empty goes straight into the shifter and skips the hold register.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_idx   <= '0;
    end else begin
      if (state == IDLE && accept) begin
        shift_reg <= data;
      end else if (state == DATA && tick) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= (bit_idx == LAST_BIT) ? 3'd0 : bit_idx + 3'd1;
      end else if (stop_end) begin
        if (hold_full) begin
          shift_reg <= hold_reg;
          hold_full <= 1'b0;
        end else if (accept) begin
          shift_reg <= data;
        end
      end

      if (accept && state != IDLE && !stop_end) begin
        hold_reg  <= data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: every accepted byte is queued, and each frame decoded from tx is
// compared sample by sample against an ideal 8N1 waveform built from the queued byte.
module tb_uart_tx;

  localparam int SC        = 16;
  localparam int FRAME_LEN = 10 * SC;

  typedef logic [FRAME_LEN-1:0] wide_t;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] expq[$];

  int    cycle        = 0;
  int    busyCycles   = 0;
  int    frameCount   = 0;
  int    lastFrameEnd = 0;
  int    frameGap     = 0;
  bit    inFrame      = 0;
  int    idx          = 0;
  wide_t actualWave;
  wide_t expWave;
  logic [7:0] expByte;
  int    bitNum;

  uart_tx #(
    .SAMPLE_COUNT(SC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offers a byte. valid stays high on return so that callers can chain bytes.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    data  = b;
    valid = 1'b1;
    while (!ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      checkOutput("accept_timeout", wide_t'(1), wide_t'(0));
      valid = 1'b0;
    end else begin
      expq.push_back(b);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", wide_t'(1), wide_t'(0));
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: decodes frames from tx and compares them against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        inFrame = 0;
        idx     = 0;
        continue;
      end
      if (busy) busyCycles++;
      if (!inFrame && tx == 1'b0) begin
        inFrame  = 1;
        idx      = 0;
        frameGap = cycle - lastFrameEnd;
      end
      if (inFrame) begin
        actualWave[idx] = tx;
        idx++;
        if (idx == FRAME_LEN) begin
          inFrame      = 0;
          lastFrameEnd = cycle;
          frameCount++;
          if (expq.size() == 0) begin
            checkOutput("unexpected_frame", wide_t'(1), wide_t'(0));
          end else begin
            expByte = expq.pop_front();
            for (int i = 0; i < FRAME_LEN; i++) begin
              bitNum = i / SC;
              if (bitNum == 0)      expWave[i] = 1'b0;
              else if (bitNum == 9) expWave[i] = 1'b1;
              else                  expWave[i] = expByte[bitNum-1];
            end
            checkOutput("frame_wave", actualWave, expWave);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fc;
    int bad;
    int lowCnt;

    reset = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_tx", wide_t'(tx), wide_t'(1));
    checkOutput("reset_busy", wide_t'(busy), wide_t'(0));
    checkOutput("reset_ready", wide_t'(ready), wide_t'(1));

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
    end
    checkOutput("idle_hold", wide_t'(bad), wide_t'(0));
    checkOutput("idle_no_frames", wide_t'(frameCount), wide_t'(0));

    // Single 0x55 frame. data is changed after the accept and must not matter.
    busyCycles = 0;
    fc = frameCount;
    applyStimulus(8'h55);
    valid = 1'b0;
    data  = 8'hFF;
    checkOutput("start_latency", wide_t'({busy, tx, ready}), wide_t'(3'b101));
    waitIdle(400);
    checkOutput("busy_len_55", wide_t'(busyCycles), wide_t'(FRAME_LEN));
    checkOutput("frames_55", wide_t'(frameCount - fc), wide_t'(1));

    // 0xAA then 0xF0 with valid held: the second byte waits in hold.
    busyCycles = 0;
    fc = frameCount;
    applyStimulus(8'hAA);
    applyStimulus(8'hF0);
    valid = 1'b0;
    checkOutput("hold_ready_low", wide_t'(ready), wide_t'(0));
    lowCnt = 0;
    while (lowCnt < 1000) begin
      @(negedge clk);
      if (ready) break;
      lowCnt++;
    end
    checkOutput("ready_low_len", wide_t'(lowCnt), wide_t'(FRAME_LEN - 1));
    waitIdle(800);
    checkOutput("busy_len_b2b", wide_t'(busyCycles), wide_t'(2 * FRAME_LEN));
    checkOutput("gap_b2b", wide_t'(frameGap), wide_t'(1));
    checkOutput("frames_b2b", wide_t'(frameCount - fc), wide_t'(2));

    // Four bytes back to back, decoded by the monitor in order.
    busyCycles = 0;
    fc = frameCount;
    applyStimulus(8'h55);
    applyStimulus(8'hAA);
    applyStimulus(8'hF0);
    applyStimulus(8'h0F);
    valid = 1'b0;
    waitIdle(1600);
    checkOutput("frames_loop", wide_t'(frameCount - fc), wide_t'(4));
    checkOutput("busy_len_loop", wide_t'(busyCycles), wide_t'(4 * FRAME_LEN));
    checkOutput("queue_empty_loop", wide_t'(expq.size()), wide_t'(0));

    // Reset during data bit 3 of 0x0F while 0x3C sits in hold.
    applyStimulus(8'h0F);
    applyStimulus(8'h3C);
    valid = 1'b0;
    checkOutput("hold_loaded", wide_t'(ready), wide_t'(0));
    repeat (70) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_tx", wide_t'(tx), wide_t'(1));
    checkOutput("midreset_busy", wide_t'(busy), wide_t'(0));
    checkOutput("midreset_ready", wide_t'(ready), wide_t'(1));
    reset = 1'b0;
    expq.delete();
    fc = frameCount;
    busyCycles = 0;
    repeat (400) @(negedge clk);
    checkOutput("post_reset_frames", wide_t'(frameCount - fc), wide_t'(0));
    checkOutput("post_reset_busy", wide_t'(busyCycles), wide_t'(0));

    // Accept on the exact edge that ends the stop bit, with hold empty.
    fc = frameCount;
    applyStimulus(8'h5A);
    valid = 1'b0;
    repeat (FRAME_LEN - 1) @(posedge clk);
    #1;
    checkOutput("pre_stop_tx", wide_t'({busy, tx, ready}), wide_t'(3'b111));
    data  = 8'hC3;
    valid = 1'b1;
    expq.push_back(8'hC3);
    @(posedge clk);
    #1;
    valid = 1'b0;
    checkOutput("same_edge_start", wide_t'({busy, tx, ready}), wide_t'(3'b101));
    waitIdle(800);
    checkOutput("frames_same_edge", wide_t'(frameCount - fc), wide_t'(2));
    checkOutput("gap_same_edge", wide_t'(frameGap), wide_t'(1));
    checkOutput("queue_empty_end", wide_t'(expq.size()), wide_t'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
